// File: rtl/tile_writeback_logic.sv
// Tile write-back path: takes one tile of result words from a valid/ready
// producer stream and writes them to the shared tile BRAM. Each tile goes to
// the next free tile slot of the selected logical buffer (Weights, K, V).
module tile_writeback_logic #(
  parameter int NUM_WRITES_PER_TILE = 2,
  parameter int ADDR_WIDTH          = 11,
  parameter int DATA_WIDTH          = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_write,
  input  logic                  reset_addr_counters,
  input  logic [1:0]            buffer_select,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  write_done,
  output logic                  select_err
);

  localparam int unsigned OFF_W  = (NUM_WRITES_PER_TILE > 1) ? $clog2(NUM_WRITES_PER_TILE) : 1;
  localparam int unsigned NW     = NUM_WRITES_PER_TILE;
  localparam int unsigned BASE_W = 0;
  localparam int unsigned BASE_K = 4;
  localparam int unsigned BASE_V = 772;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_WRITES_PER_TILE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITING,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [1:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [OFF_W-1:0]        off_q;
  logic [8:0]              ptr_q [3];
  logic                    in_ready_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [DATA_WIDTH-1:0]   bram_din_q;
  logic                    wr_q;
  logic                    write_done_q;
  logic                    select_err_q;

  logic [ADDR_WIDTH-1:0]   start_base_d;
  logic [ADDR_WIDTH-1:0]   tile_addr_d;
  int unsigned             sel_base;
  logic [8:0]              sel_ptr;

  // Start address for the requested buffer and the address of the current beat.
  always_comb begin
    sel_base = 0;
    sel_ptr  = '0;
    case (buffer_select)
      2'b00:   begin sel_base = BASE_W; sel_ptr = ptr_q[0]; end
      2'b01:   begin sel_base = BASE_K; sel_ptr = ptr_q[1]; end
      2'b10:   begin sel_base = BASE_V; sel_ptr = ptr_q[2]; end
      default: begin sel_base = 0;      sel_ptr = '0;       end
    endcase
    start_base_d = ADDR_WIDTH'(sel_base + 32'(sel_ptr) * NW);
    tile_addr_d  = ADDR_WIDTH'(32'(base_q) + 32'(off_q));
  end

  // Tile sequencing FSM with registered outputs and per-buffer tile pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      base_q       <= '0;
      off_q        <= '0;
      in_ready_q   <= 1'b0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      wr_q         <= 1'b0;
      write_done_q <= 1'b0;
      select_err_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) ptr_q[i] <= '0;
    end else begin
      wr_q         <= 1'b0;
      write_done_q <= 1'b0;
      select_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_write) begin
            if (buffer_select == 2'b11) begin
              select_err_q <= 1'b1;
            end else begin
              sel_q      <= buffer_select;
              base_q     <= start_base_d;
              off_q      <= '0;
              in_ready_q <= 1'b1;
              state_q    <= S_WRITING;
            end
          end
        end

        S_WRITING: begin
          if (in_valid) begin
            bram_addr_q <= tile_addr_d;
            bram_din_q  <= in_data;
            wr_q        <= 1'b1;
            off_q       <= off_q + 1'b1;
            if (off_q == LAST_OFF) begin
              in_ready_q <= 1'b0;
              state_q    <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          write_done_q <= 1'b1;
          state_q      <= S_DONE;
        end

        S_DONE: begin
          ptr_q[sel_q] <= ptr_q[sel_q] + 9'd1;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // Placed last so a clear wins over the DONE increment in the same cycle.
      if (reset_addr_counters) begin
        for (int unsigned i = 0; i < 3; i++) ptr_q[i] <= '0;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign bram_en    = wr_q;
  assign bram_we    = wr_q;
  assign write_done = write_done_q;
  assign select_err = select_err_q;

endmodule

// File: tb/tb_tile_writeback_logic.sv
// Directed bench for tile_writeback_logic: addresses, data, timing, stalls,
// pointer clear/wrap, illegal select and mid-tile reset.
module tb_tile_writeback_logic;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_write = 1'b0;
  logic          reset_addr_counters = 1'b0;
  logic [1:0]    buffer_select = 2'b00;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_en;
  logic          bram_we;
  logic          write_done;
  logic          select_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Observations of the most recent tile
  int            nwr;
  int            done_cyc;
  int            start_cyc;
  logic [AW-1:0] wr_addr [4];
  logic [DW-1:0] wr_data [4];
  int            wr_cyc  [4];

  tile_writeback_logic #(
    .NUM_WRITES_PER_TILE(N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_write(start_write),
    .reset_addr_counters(reset_addr_counters),
    .buffer_select(buffer_select),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bram_addr(bram_addr),
    .bram_din(bram_din),
    .bram_en(bram_en),
    .bram_we(bram_we),
    .write_done(write_done),
    .select_err(select_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one tile (inputs change at negedge, outputs observed at negedge).
  // stall = number of idle in_valid cycles inserted before the second beat.
  task automatic do_tile(input logic [1:0] sel, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input int stall, input bit rac_at_done);
    int beat = 0;
    int stall_left = stall;
    nwr = 0;
    done_cyc = -1;
    @(negedge clk);
    reset_addr_counters = 1'b0;
    start_write = 1'b1;
    buffer_select = sel;
    in_valid = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      start_write = 1'b0;
      reset_addr_counters = 1'b0;
      if (bram_we === 1'b1 && nwr < 4) begin
        wr_addr[nwr] = bram_addr;
        wr_data[nwr] = bram_din;
        wr_cyc[nwr]  = cyc;
        nwr++;
      end
      if (write_done === 1'b1) begin
        done_cyc = cyc;
        if (rac_at_done) reset_addr_counters = 1'b1;
      end
      if (in_ready === 1'b1 && beat < 2) begin
        if (beat == 1 && stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = 1'b1;
          in_data = (beat == 0) ? d0 : d1;
          beat++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready   !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0h expected 0", in_ready); end
    checks++; if (bram_addr  !== '0)   begin errors++; $display("FAIL reset_bram_addr: got %0h expected 0", bram_addr); end
    checks++; if (bram_din   !== '0)   begin errors++; $display("FAIL reset_bram_din: got %0h expected 0", bram_din); end
    checks++; if (bram_en    !== 1'b0) begin errors++; $display("FAIL reset_bram_en: got %0h expected 0", bram_en); end
    checks++; if (bram_we    !== 1'b0) begin errors++; $display("FAIL reset_bram_we: got %0h expected 0", bram_we); end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL reset_write_done: got %0h expected 0", write_done); end
    checks++; if (select_err !== 1'b0) begin errors++; $display("FAIL reset_select_err: got %0h expected 0", select_err); end
    rst = 1'b0;
  endtask

  task automatic test_weights();
    logic [DW-1:0] a = 64'hA5A5_0000_1111_2222;
    logic [DW-1:0] b = 64'h0123_4567_89AB_CDEF;
    do_tile(2'b00, a, b, 0, 1'b0);
    checks++; if (nwr !== 2) begin errors++; $display("FAIL w0_nwrites: got %0d expected 2", nwr); end
    checks++; if (wr_addr[0] !== 11'd0) begin errors++; $display("FAIL w0_addr0: got %0d expected 0", wr_addr[0]); end
    checks++; if (wr_addr[1] !== 11'd1) begin errors++; $display("FAIL w0_addr1: got %0d expected 1", wr_addr[1]); end
    checks++; if (wr_data[0] !== a) begin errors++; $display("FAIL w0_data0: got %0h expected %0h", wr_data[0], a); end
    checks++; if (wr_data[1] !== b) begin errors++; $display("FAIL w0_data1: got %0h expected %0h", wr_data[1], b); end
    checks++; if (wr_cyc[0] !== start_cyc + 2) begin errors++; $display("FAIL w0_wr0_time: got %0d expected %0d", wr_cyc[0], start_cyc + 2); end
    checks++; if (wr_cyc[1] !== start_cyc + 3) begin errors++; $display("FAIL w0_wr1_time: got %0d expected %0d", wr_cyc[1], start_cyc + 3); end
    checks++; if (done_cyc !== start_cyc + 4) begin errors++; $display("FAIL w0_done_time: got %0d expected %0d", done_cyc, start_cyc + 4); end
    do_tile(2'b00, 64'h11, 64'h22, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd2 || wr_addr[1] !== 11'd3 || nwr !== 2)
      begin errors++; $display("FAIL w1_addrs: got %0d,%0d (n=%0d) expected 2,3", wr_addr[0], wr_addr[1], nwr); end
  endtask

  task automatic test_back_to_back();
    int prev_done;
    do_tile(2'b01, 64'h33, 64'h44, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd4 || wr_addr[1] !== 11'd5 || nwr !== 2)
      begin errors++; $display("FAIL k0_addrs: got %0d,%0d (n=%0d) expected 4,5", wr_addr[0], wr_addr[1], nwr); end
    prev_done = done_cyc;
    do_tile(2'b01, 64'h55, 64'h66, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd6 || wr_addr[1] !== 11'd7 || nwr !== 2)
      begin errors++; $display("FAIL k1_addrs: got %0d,%0d (n=%0d) expected 6,7", wr_addr[0], wr_addr[1], nwr); end
    checks++; if (done_cyc !== prev_done + 5)
      begin errors++; $display("FAIL k_turnaround: got %0d expected %0d", done_cyc, prev_done + 5); end
    do_tile(2'b10, 64'h77, 64'h88, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd772 || wr_addr[1] !== 11'd773 || nwr !== 2)
      begin errors++; $display("FAIL v0_addrs: got %0d,%0d (n=%0d) expected 772,773", wr_addr[0], wr_addr[1], nwr); end
  endtask

  task automatic test_stall();
    do_tile(2'b00, 64'hAA, 64'hBB, 3, 1'b0);
    checks++; if (nwr !== 2) begin errors++; $display("FAIL stall_nwrites: got %0d expected 2", nwr); end
    checks++; if (wr_addr[0] !== 11'd4 || wr_addr[1] !== 11'd5)
      begin errors++; $display("FAIL stall_addrs: got %0d,%0d expected 4,5", wr_addr[0], wr_addr[1]); end
    checks++; if (wr_data[1] !== 64'hBB) begin errors++; $display("FAIL stall_data1: got %0h expected bb", wr_data[1]); end
    checks++; if (wr_cyc[1] - wr_cyc[0] !== 4)
      begin errors++; $display("FAIL stall_write_gap: got %0d expected 4", wr_cyc[1] - wr_cyc[0]); end
    checks++; if (done_cyc !== start_cyc + 7)
      begin errors++; $display("FAIL stall_done_time: got %0d expected %0d", done_cyc, start_cyc + 7); end
  endtask

  task automatic test_counter_clear();
    logic [AW-1:0] exp_a;
    // V pointer is 1 here; bring it to 5
    for (int i = 1; i < 5; i++) begin
      do_tile(2'b10, 64'(i), 64'(i + 100), 0, 1'b0);
      exp_a = 11'(772 + 2 * i);
      checks++; if (wr_addr[0] !== exp_a)
        begin errors++; $display("FAIL vfill_addr%0d: got %0d expected %0d", i, wr_addr[0], exp_a); end
    end
    do_tile(2'b10, 64'hC0, 64'hC1, 0, 1'b1);
    checks++; if (wr_addr[0] !== 11'd782 || wr_addr[1] !== 11'd783)
      begin errors++; $display("FAIL v5_addrs: got %0d,%0d expected 782,783", wr_addr[0], wr_addr[1]); end
    do_tile(2'b10, 64'hC2, 64'hC3, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd772 || wr_addr[1] !== 11'd773)
      begin errors++; $display("FAIL v_after_clear: got %0d,%0d expected 772,773", wr_addr[0], wr_addr[1]); end
    do_tile(2'b01, 64'hC4, 64'hC5, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd4 || wr_addr[1] !== 11'd5)
      begin errors++; $display("FAIL k_after_clear: got %0d,%0d expected 4,5", wr_addr[0], wr_addr[1]); end
  endtask

  task automatic test_wrap();
    // Weights pointer is 0 after the clear; advance it to 511
    for (int i = 0; i < 511; i++) do_tile(2'b00, 64'(i), 64'(~i), 0, 1'b0);
    do_tile(2'b00, 64'hD0, 64'hD1, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd1022 || wr_addr[1] !== 11'd1023)
      begin errors++; $display("FAIL w511_addrs: got %0d,%0d expected 1022,1023", wr_addr[0], wr_addr[1]); end
    do_tile(2'b00, 64'hD2, 64'hD3, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd0 || wr_addr[1] !== 11'd1)
      begin errors++; $display("FAIL w_wrap_addrs: got %0d,%0d expected 0,1", wr_addr[0], wr_addr[1]); end
  endtask

  task automatic test_select_err();
    @(negedge clk);
    start_write = 1'b1;
    buffer_select = 2'b11;
    in_valid = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    checks++; if (select_err !== 1'b1) begin errors++; $display("FAIL selerr_pulse: got %0h expected 1", select_err); end
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL selerr_no_we: got %0h expected 0", bram_we); end
    @(negedge clk);
    checks++; if (select_err !== 1'b0) begin errors++; $display("FAIL selerr_one_cycle: got %0h expected 0", select_err); end
    checks++; if (in_ready !== 1'b0 || bram_we !== 1'b0)
      begin errors++; $display("FAIL selerr_stays_idle: got ready=%0h we=%0h expected 0,0", in_ready, bram_we); end
    in_valid = 1'b0;
  endtask

  task automatic test_rst_mid_tile();
    int seen = 0;
    @(negedge clk);
    reset_addr_counters = 1'b1;
    @(negedge clk);
    reset_addr_counters = 1'b0;
    start_write = 1'b1;
    buffer_select = 2'b00;
    @(negedge clk);
    start_write = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_ready: got %0h expected 1", in_ready); end
    in_valid = 1'b1;
    in_data = 64'hE0;
    @(negedge clk);
    checks++; if (bram_we !== 1'b1 || bram_addr !== 11'd0)
      begin errors++; $display("FAIL rst_first_beat: got we=%0h addr=%0d expected 1,0", bram_we, bram_addr); end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({in_ready, bram_en, bram_we, write_done, select_err} !== 5'b0 || bram_addr !== '0 || bram_din !== '0)
      begin errors++; $display("FAIL rst_outputs: got ready=%0h en=%0h we=%0h done=%0h err=%0h addr=%0h din=%0h expected all 0",
                               in_ready, bram_en, bram_we, write_done, select_err, bram_addr, bram_din); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (write_done === 1'b1 || bram_we === 1'b1 || in_ready === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_abandoned: got %0d active cycles expected 0", seen); end
    do_tile(2'b00, 64'hE1, 64'hE2, 0, 1'b0);
    checks++; if (wr_addr[0] !== 11'd0 || wr_addr[1] !== 11'd1 || nwr !== 2)
      begin errors++; $display("FAIL rst_restart_addrs: got %0d,%0d (n=%0d) expected 0,1", wr_addr[0], wr_addr[1], nwr); end
    checks++; if (done_cyc !== start_cyc + 4)
      begin errors++; $display("FAIL rst_restart_done: got %0d expected %0d", done_cyc, start_cyc + 4); end
  endtask

  initial begin
    test_reset();
    test_weights();
    test_back_to_back();
    test_stall();
    test_counter_clear();
    test_wrap();
    test_select_err();
    test_rst_mid_tile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_writeback_logic.md
# tile_writeback_logic

Write-side counterpart of the tile fetch path. It accepts a tile's worth of result words from a producer over a valid/ready stream and writes them into the shared tile BRAM. Each tile lands at the next free tile slot of the selected logical buffer (Weights, K-Matrix, V-Matrix). It sits between the compute datapath output and the BRAM write port, under arbiter control.

## Interface

**Parameters**
- NUM_WRITES_PER_TILE, 2 — BRAM words per tile (≥2).
- ADDR_WIDTH, 11 — BRAM address width.
- DATA_WIDTH, 64 — BRAM word width.

**Ports**
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_write  in  1  pulse; begins writing one tile; honoured only in IDLE.
- reset_addr_counters  in  1  pulse; clears all three tile pointers.
- buffer_select  in  2  00 Weights, 01 K-Matrix, 10 V-Matrix, 11 illegal; sampled with start_write.
- in_data  in  DATA_WIDTH  producer word.
- in_valid  in  1  producer word valid.
- in_ready  out  1  block accepts a word this cycle.
- bram_addr  out  ADDR_WIDTH  write address (registered).
- bram_din  out  DATA_WIDTH  write data (registered).
- bram_en  out  1  BRAM port enable (registered).
- bram_we  out  1  BRAM write enable (registered; equals bram_en).
- write_done  out  1  one-cycle pulse after the tile's last BRAM write.
- select_err  out  1  one-cycle pulse when start_write arrives with buffer_select = 11.

## Operation

- Memory map bases: Weights 0, K-Matrix 4, V-Matrix 772.
- Three 9-bit tile pointers, one per buffer. Each resets to 0.
- States:
  - IDLE: in_ready = 0. On start_write with a legal select:
    - latch sel;
    - latch base = BASE[sel] + ptr[sel]·NUM_WRITES_PER_TILE, truncated to ADDR_WIDTH;
    - clear offset;
    - go to WRITING.
  - IDLE, start_write with select 11: stay in IDLE and pulse select_err next cycle.
  - WRITING: in_ready = 1.
    - Each accepted beat (in_valid & in_ready) registers bram_addr = base + offset, bram_din = in_data and bram_en = bram_we = 1 for the next cycle, then increments offset.
    - in_valid low: no write issued and offset holds (stall, no timeout).
    - Acceptance of beat NUM_WRITES_PER_TILE−1 moves the FSM to FLUSH.
  - FLUSH: in_ready = 0. The final write is on the port. Go to DONE.
  - DONE: write_done = 1. ptr[latched sel] increments by 1, modulo 512. Go to IDLE.
- buffer_select is used only at start. Changes during a tile have no effect.
- start_write outside IDLE is ignored and not queued.
- reset_addr_counters clears all pointers in any state.
  - It takes priority over the DONE increment in the same cycle; the pointer ends at 0.
  - It does not affect a tile in flight, whose base is already latched.
- Pointer wrap: 511 + 1 → 0. No overflow flag.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. There is no region-bound check; the arbiter keeps pointers within their region.

## Timing

- Reset values: in_ready 0, bram_addr 0, bram_din 0, bram_en 0, bram_we 0, write_done 0, select_err 0, state IDLE, pointers 0, offset 0.
- rst mid-tile: the next cycle is IDLE with all outputs at reset values. The partial tile is abandoned and the pointer is not advanced.
- start_write at cycle t → WRITING at t+1, so in_ready first rises at t+1.
- Beat accepted at cycle c → bram_we high at c+1 with that beat's address and data.
- With in_valid held high from t+1, beats are accepted at t+1 … t+N, where N = NUM_WRITES_PER_TILE.
  - Writes occur at t+2 … t+N+1.
  - FLUSH is cycle t+N+1.
  - write_done pulses at t+N+2.
  - IDLE at t+N+3; the earliest next start_write is at t+N+3.
- Minimum tile turnaround is N+3 cycles.
- The pointer's updated value is visible from t+N+3.

## Test plan

- Reset, then start_write with select 00 and in_valid held high with data A, B. Required: bram_we high for two cycles at addr 0 then 1 with data A then B; write_done pulses 2 cycles after the last accept; a second Weights tile writes addrs 2, 3.
- Select 01, two tiles back-to-back. Required: addrs 4, 5, then 6, 7. Select 10 first tile: addrs 772, 773.
- Stall: in_valid deasserted for 3 cycles between beats. Required: no bram_we during the stall, offset held, final addresses unchanged, write_done delayed by exactly 3 cycles.
- reset_addr_counters asserted in the same cycle as DONE of a V tile (pointer 5). Required: the V pointer reads 0 and the next V tile writes 772, 773.
- Preload the Weights pointer to 511 (511 tiles). Required: that tile writes 1022, 1023 and the next writes 0, 1. Also: start_write with select 11 → select_err pulse, no bram_we, FSM stays IDLE.
- rst asserted after the first beat is accepted. Required: all outputs 0 next cycle, no write_done, and a restarted tile reuses the same base address.
